data_memory_arbiter: RTL and testbench

Shares the single-ported data memory between two requesters: the core load/store unit (port 0) and the matmul tile DMA (port 1). Each cycle at most one access is forwarded to the memory. Grants are combinational. Read data is registered and returned one cycle later. Contention is resolved with a sticky round-robin policy bounded by a burst limit. The block sits between the pipeline MEM stage / DMA engine and `data_memory`.

---
 rtl/data_memory_arbiter_pkg.sv | 12 +
 rtl/data_memory_arbiter_if.sv | 36 +++
 rtl/data_memory_arbiter_rr_burst_arbiter.sv | 57 +++++
 rtl/data_memory_arbiter.sv | 60 ++++++
 tb/tb_data_memory_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared constants for the data-memory path.
//   WORD_W    : memory word width
//   BE_W      : byte enables per word
//   PORT_CORE : requester index of the core load/store unit
//   PORT_DMA  : requester index of the matmul tile DMA
package mem_pkg;
  localparam int WORD_W    = 32;
  localparam int BE_W      = 4;
  localparam int NUM_PORTS = 2;
  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;
endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two requester ports and the memory-side port.
//   slave  : arbiter view (requests in, grants/read data/memory controls out)
//   master : requester + memory view (the opposite directions)
interface data_memory_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              p0_req,     p1_req;
  logic              p0_we,      p1_we;
  logic [ADDR_W-1:0] p0_addr,    p1_addr;
  logic [WORD_W-1:0] p0_wdata,   p1_wdata;
  logic [BE_W-1:0]   p0_byte_en, p1_byte_en;
  logic              p0_gnt,     p1_gnt;
  logic              p0_rvalid,  p1_rvalid;
  logic [WORD_W-1:0] p0_rdata,   p1_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_en;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p0_byte_en, p1_byte_en, mem_rdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           mem_we, mem_addr, mem_wdata, mem_byte_en
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p0_byte_en, p1_byte_en, mem_rdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           mem_we, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/data_memory_arbiter_rr_burst_arbiter.sv
// Two-port sticky round-robin arbiter with a burst limit.
//   clk, reset : clock, synchronous active-low reset
//   req[1:0]   : per-port request
//   gnt[1:0]   : combinational one-hot grant (zero when idle)
// State: owner (last granted port), burst_cnt (grants in the current run).
module rr_burst_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic             owner,     owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             win;

  always_comb begin
    gnt           = '0;
    win           = owner;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      // Owner keeps the memory only while a run is in progress and under the
      // limit; a fresh tie (no run) goes to the other port, which is why
      // resetting owner to 1 hands port 0 the first tie.
      2'b11:   win = (burst_cnt != '0 && burst_cnt < CNT_MAX) ? owner : ~owner;
      default: win = owner;
    endcase
    if (|req) begin
      gnt[win] = 1'b1;
      if (win == owner && &req) begin
        burst_cnt_nxt = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
      end else begin
        burst_cnt_nxt = CNT_W'(1);
        owner_nxt     = win;
      end
    end else begin
      burst_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner     <= 1'b1;
      burst_cnt <= '0;
    end else begin
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end
endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-ported data memory between the core LSU (port 0) and
// the matmul tile DMA (port 1). One access per cycle, grant in the same
// cycle, load data registered and returned one cycle after the grant.
//   clk, reset : clock, synchronous active-low reset
//   bus        : requester ports p0_*/p1_* and memory port mem_*
module data_memory_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_arbiter_if.slave  bus
);
  logic [NUM_PORTS-1:0]             req, gnt, we, ld;
  logic [NUM_PORTS-1:0]             rvalid_q;
  logic [NUM_PORTS-1:0][WORD_W-1:0] rdata_q;
  logic [ADDR_W-1:0]                addr_sel;

  assign req = {bus.p1_req, bus.p0_req};
  assign we  = {bus.p1_we,  bus.p0_we};
  assign ld  = gnt & ~we;

  rr_burst_arbiter #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.p0_gnt = gnt[PORT_CORE];
  assign bus.p1_gnt = gnt[PORT_DMA];

  // Port 0 is the default path when nothing is granted.
  assign addr_sel        = gnt[PORT_DMA] ? bus.p1_addr    : bus.p0_addr;
  assign bus.mem_addr    = addr_sel;
  assign bus.mem_wdata   = gnt[PORT_DMA] ? bus.p1_wdata   : bus.p0_wdata;
  assign bus.mem_byte_en = gnt[PORT_DMA] ? bus.p1_byte_en : bus.p0_byte_en;
  // Grants stay combinational during reset, so the store strobe is gated
  // to keep a reset cycle from corrupting memory.
  assign bus.mem_we      = reset & |(gnt & we);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rvalid_q[i] <= ld[i];
        if (ld[i]) rdata_q[i] <= bus.mem_rdata;
      end
    end
  end

  assign bus.p0_rvalid = rvalid_q[PORT_CORE];
  assign bus.p1_rvalid = rvalid_q[PORT_DMA];
  assign bus.p0_rdata  = rdata_q[PORT_CORE];
  assign bus.p1_rdata  = rdata_q[PORT_DMA];
endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  logic do_init;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_memory_arbiter_if #(.ADDR_W(32)) bus ();

  data_memory_arbiter #(.MAX_BURST(MB), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural single-ported memory: combinational read, byte-enabled write.
  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'hDEADBEEF;
      mem[64] <= 32'hCAFEBABE;
      mem[65] <= 32'h00000099;
    end else if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byte_en[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int p, input logic rq, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    if (p == 0) begin
      bus.p0_req = rq; bus.p0_we = w; bus.p0_addr = a; bus.p0_wdata = wd; bus.p0_byte_en = be;
    end else begin
      bus.p1_req = rq; bus.p1_we = w; bus.p1_addr = a; bus.p1_wdata = wd; bus.p1_byte_en = be;
    end
  endtask

  task automatic idle();
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Arbitration table: requests and expected grants, all loads.
  typedef struct packed {
    logic r0, r1, g0, g1;
  } arb_vec_t;
  arb_vec_t tbl [15];

  // Randomised phase: pending requester transactions and reference state.
  typedef struct {
    bit          act;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } preq_t;
  preq_t       pr [2];
  logic [31:0] sh [0:255];
  logic [31:0] exp_rd [2];
  bit          exp_rv [2];
  int          last_port, run;

  initial begin
    for (int i = 0; i < 9; i++)
      tbl[i] = {1'b1, 1'b1, (i < 4 || i == 8), (i >= 4 && i < 8)};
    tbl[9]  = {1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = {1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = {1'b1, 1'b1, 1'b0, 1'b1};
    tbl[12] = {1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = {1'b1, 1'b1, 1'b1, 1'b0};
    tbl[14] = {1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b0; do_init = 1'b1; idle();
    step();
    do_init = 1'b0;
    mid();
    chk("reset_p0_rvalid", 32'(bus.p0_rvalid), 0);
    chk("reset_p1_rvalid", 32'(bus.p1_rvalid), 0);
    chk("reset_p0_rdata", bus.p0_rdata, 0);
    chk("reset_p1_rdata", bus.p1_rdata, 0);
    step();
    reset = 1'b1;

    // Lone p0 load of the preset word.
    drv(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    mid();
    chk("t1_p0_gnt", 32'(bus.p0_gnt), 1);
    chk("t1_p1_gnt", 32'(bus.p1_gnt), 0);
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_mem_we", 32'(bus.mem_we), 0);
    step(); idle(); mid();
    chk("t1_p0_rvalid", 32'(bus.p0_rvalid), 1);
    chk("t1_p0_rdata", bus.p0_rdata, 32'hCAFEBABE);
    chk("t1_p1_rvalid", 32'(bus.p1_rvalid), 0);
    step(); mid();
    chk("t1_p0_rvalid_pulse", 32'(bus.p0_rvalid), 0);
    chk("t1_p0_rdata_hold", bus.p0_rdata, 32'hCAFEBABE);

    // Contention sequence straight out of reset.
    step(); reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drv(0, tbl[i].r0, 1'b0, 32'h100, 32'h0, 4'h0);
      drv(1, tbl[i].r1, 1'b0, 32'h104, 32'h0, 4'h0);
      mid();
      chk($sformatf("tbl%0d_gnt", i), 32'({bus.p1_gnt, bus.p0_gnt}), 32'({tbl[i].g1, tbl[i].g0}));
      chk($sformatf("tbl%0d_mem_we", i), 32'(bus.mem_we), 0);
      step();
    end

    // Cross-port store then load of the same word.
    drv(1, 1'b1, 1'b1, 32'h104, 32'h000000AA, 4'b0001);
    mid();
    chk("t3_p1_gnt", 32'(bus.p1_gnt), 1);
    chk("t3_mem_we", 32'(bus.mem_we), 1);
    chk("t3_mem_wdata", bus.mem_wdata, 32'hAA);
    chk("t3_mem_be", 32'(bus.mem_byte_en), 1);
    step(); idle();
    drv(0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    mid();
    chk("t3_p0_gnt", 32'(bus.p0_gnt), 1);
    chk("t3_store_no_rvalid", 32'(bus.p1_rvalid), 0);
    step(); idle(); mid();
    chk("t3_p0_rvalid", 32'(bus.p0_rvalid), 1);
    chk("t3_p0_rdata", bus.p0_rdata, 32'hAA);
    step();

    // Tie with owner=0 and no run: p1 load wins, p0 store follows.
    drv(0, 1'b1, 1'b1, 32'h0, 32'h11223344, 4'hF);
    drv(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    mid();
    chk("t4_gnt_first", 32'({bus.p1_gnt, bus.p0_gnt}), 2);
    chk("t4_mem_we_first", 32'(bus.mem_we), 0);
    step(); drv(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); mid();
    chk("t4_p0_gnt", 32'(bus.p0_gnt), 1);
    chk("t4_mem_we", 32'(bus.mem_we), 1);
    chk("t4_p1_rvalid", 32'(bus.p1_rvalid), 1);
    chk("t4_p1_rdata", bus.p1_rdata, 32'hDEADBEEF);
    step(); idle();
    drv(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    step(); idle(); mid();
    chk("t4_readback", bus.p1_rdata, 32'h11223344);
    step();

    // Reset in the cycle after a granted p1 load, with a store pending.
    drv(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    step(); idle();
    reset = 1'b0;
    drv(0, 1'b1, 1'b1, 32'h100, 32'h55555555, 4'hF);
    mid();
    chk("t5_mem_we_gated", 32'(bus.mem_we), 0);
    step(); idle(); reset = 1'b1; mid();
    chk("t5_p1_rvalid_dropped", 32'(bus.p1_rvalid), 0);
    chk("t5_p1_rdata_cleared", bus.p1_rdata, 0);
    drv(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    drv(1, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    step(); mid();
    chk("t5_tie_after_reset", 32'({bus.p1_gnt, bus.p0_gnt}), 1);
    chk("t5_mem_unwritten", bus.p0_rdata, 32'hCAFEBABE);
    step(); idle(); step();

    // Ten back-to-back p0 loads.
    for (int i = 0; i < 10; i++) begin
      drv(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      mid();
      chk($sformatf("t6_gnt%0d", i), 32'(bus.p0_gnt), 1);
      if (i > 0) chk($sformatf("t6_rvalid%0d", i), 32'(bus.p0_rvalid), 1);
      step();
    end
    idle(); mid();
    chk("t6_rvalid_last", 32'(bus.p0_rvalid), 1);
    step(); mid();
    chk("t6_rvalid_end", 32'(bus.p0_rvalid), 0);
    step();

    // Randomised traffic against the reference model.
    reset = 1'b0; do_init = 1'b1;
    step();
    do_init = 1'b0; reset = 1'b1;
    for (int i = 0; i < 256; i++) sh[i] = 32'h0;
    sh[0] = 32'hDEADBEEF; sh[64] = 32'hCAFEBABE; sh[65] = 32'h00000099;
    for (int p = 0; p < 2; p++) begin
      pr[p].act = 1'b0; exp_rv[p] = 1'b0; exp_rd[p] = 32'h0;
    end
    last_port = 1; run = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int g;
      logic [31:0] w;
      for (int p = 0; p < 2; p++) begin
        if (!pr[p].act && $urandom_range(0, 9) < 6) begin
          pr[p].act  = 1'b1;
          pr[p].we   = ($urandom_range(0, 2) == 0);
          pr[p].addr = 32'($urandom_range(0, 15)) << 2;
          pr[p].wd   = $urandom;
          pr[p].be   = 4'($urandom_range(0, 15));
        end
        drv(p, pr[p].act, pr[p].we, pr[p].addr, pr[p].wd, pr[p].be);
      end
      g = -1;
      if (pr[0].act && pr[1].act) g = (run > 0 && run < MB) ? last_port : 1 - last_port;
      else if (pr[0].act)         g = 0;
      else if (pr[1].act)         g = 1;
      mid();
      chk("rnd_gnt", 32'({bus.p1_gnt, bus.p0_gnt}),
          (g < 0) ? 32'd0 : 32'd1 << g);
      chk("rnd_mem_we", 32'(bus.mem_we), (g >= 0 && pr[g].we) ? 32'd1 : 32'd0);
      if (g >= 0) chk("rnd_mem_addr", bus.mem_addr, pr[g].addr);
      chk("rnd_p0_rvalid", 32'(bus.p0_rvalid), 32'(exp_rv[0]));
      chk("rnd_p1_rvalid", 32'(bus.p1_rvalid), 32'(exp_rv[1]));
      chk("rnd_p0_rdata", bus.p0_rdata, exp_rd[0]);
      chk("rnd_p1_rdata", bus.p1_rdata, exp_rd[1]);
      exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
      if (g >= 0) begin
        if (g == last_port && pr[0].act && pr[1].act) run = (run < MB) ? run + 1 : run;
        else begin
          run = 1; last_port = g;
        end
        if (pr[g].we) begin
          w = sh[pr[g].addr[9:2]];
          for (int b = 0; b < 4; b++)
            if (pr[g].be[b]) w[8*b +: 8] = pr[g].wd[8*b +: 8];
          sh[pr[g].addr[9:2]] = w;
        end else begin
          exp_rv[g] = 1'b1;
          exp_rd[g] = sh[pr[g].addr[9:2]];
        end
        pr[g].act = 1'b0;
      end else begin
        run = 0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
